// File: rtl/counter_v2.sv
// Run-time configurable step counter: up/down, one-shot or auto-reload, overshoot clamped
// to the target, with start/abort control, enable-based pause and a saturating reload count.
module counter_v2 #(
    parameter int WIDTH    = 4,
    parameter int RELOAD_W = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                enable_i,
    input  logic                dir_i,
    input  logic                mode_i,
    input  logic [WIDTH-1:0]    counter_init_i,
    input  logic [WIDTH-1:0]    counter_inc_i,
    input  logic [WIDTH-1:0]    counter_target_i,
    output logic [WIDTH-1:0]    counter_value_o,
    output logic                done_o,
    output logic                busy_o,
    output logic [RELOAD_W-1:0] reload_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0]    ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RELOAD_W-1:0] ONE_R = {{(RELOAD_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_n;
    logic [WIDTH-1:0]    value_q, value_n;
    logic                done_q, done_n;
    logic                busy_q, busy_n;
    logic [RELOAD_W-1:0] reload_q, reload_n;
    logic                pending_q, pending_n;
    logic                dir_q, dir_n;
    logic                mode_q, mode_n;
    logic [WIDTH-1:0]    init_q, init_n;
    logic [WIDTH-1:0]    inc_q, inc_n;
    logic [WIDTH-1:0]    target_q, target_n;

    // Comparisons are done one bit wider so value+inc or target+inc never wraps.
    logic [WIDTH:0] up_sum, down_lim;
    logic           step_terminal, start_terminal;
    logic [WIDTH-1:0] step_value;

    assign up_sum     = {1'b0, value_q} + {1'b0, inc_q};
    assign down_lim   = {1'b0, target_q} + {1'b0, inc_q};
    assign step_value = dir_q ? (value_q - inc_q) : (value_q + inc_q);
    assign step_terminal = dir_q ? ({1'b0, value_q} <= down_lim)
                                 : (up_sum >= {1'b0, target_q});
    assign start_terminal = dir_i ? (counter_init_i <= counter_target_i)
                                  : (counter_init_i >= counter_target_i);

    // NOTE: every signal gets its hold value first, so no path through this block
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state_q;
        value_n   = value_q;
        done_n    = done_q;
        reload_n  = reload_q;
        pending_n = pending_q;
        dir_n     = dir_q;
        mode_n    = mode_q;
        init_n    = init_q;
        inc_n     = inc_q;
        target_n  = target_q;

        if (abort_i) begin
            state_n   = IDLE;
            done_n    = 1'b0;
            pending_n = 1'b0;
        end else if (start_i) begin
            dir_n    = dir_i;
            mode_n   = mode_i;
            init_n   = counter_init_i;
            inc_n    = (counter_inc_i == '0) ? ONE_W : counter_inc_i;
            target_n = counter_target_i;
            if (start_terminal) begin
                value_n   = counter_target_i;
                done_n    = 1'b1;
                reload_n  = ONE_R;
                pending_n = mode_i;
                state_n   = mode_i ? RUN : DONE;
            end else begin
                value_n   = counter_init_i;
                done_n    = 1'b0;
                reload_n  = '0;
                pending_n = 1'b0;
                state_n   = RUN;
            end
        end else if (state_q == RUN) begin
            // In RUN done is only ever the auto-reload pulse, so it always drops here.
            done_n = 1'b0;
            if (enable_i) begin
                if (pending_q) begin
                    value_n   = init_q;
                    pending_n = 1'b0;
                end else if (step_terminal) begin
                    value_n  = target_q;
                    done_n   = 1'b1;
                    reload_n = (reload_q == '1) ? reload_q : reload_q + ONE_R;
                    if (mode_q) pending_n = 1'b1;
                    else        state_n   = DONE;
                end else begin
                    value_n = step_value;
                end
            end
        end

        busy_n = (state_n == RUN);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            value_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            reload_q  <= '0;
            pending_q <= 1'b0;
            dir_q     <= 1'b0;
            mode_q    <= 1'b0;
            init_q    <= '0;
            inc_q     <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_n;
            value_q   <= value_n;
            done_q    <= done_n;
            busy_q    <= busy_n;
            reload_q  <= reload_n;
            pending_q <= pending_n;
            dir_q     <= dir_n;
            mode_q    <= mode_n;
            init_q    <= init_n;
            inc_q     <= inc_n;
            target_q  <= target_n;
        end
    end

    assign counter_value_o = value_q;
    assign done_o          = done_q;
    assign busy_o          = busy_q;
    assign reload_cnt_o    = reload_q;

endmodule

// File: tb/tb_counter_v2.sv
// Scoreboard bench for counter_v2: each stimulus cycle queues the expected post-edge
// outputs; an independent monitor pops and compares one entry after every rising edge.
module tb_counter_v2;

    typedef struct {
        logic [3:0] value;
        logic       done;
        logic       busy;
        logic [3:0] rcnt;
        string      name;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       reset_i, start_i, abort_i, enable_i, dir_i, mode_i;
    logic [3:0] counter_init_i, counter_inc_i, counter_target_i;
    logic [3:0] counter_value_o, reload_cnt_o;
    logic       done_o, busy_o;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    counter_v2 #(.WIDTH(4), .RELOAD_W(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .enable_i(enable_i), .dir_i(dir_i), .mode_i(mode_i),
        .counter_init_i(counter_init_i), .counter_inc_i(counter_inc_i),
        .counter_target_i(counter_target_i), .counter_value_o(counter_value_o),
        .done_o(done_o), .busy_o(busy_o), .reload_cnt_o(reload_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: one expectation per rising edge, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (counter_value_o !== e.value || done_o !== e.done ||
                    busy_o !== e.busy || reload_cnt_o !== e.rcnt) begin
                    miscompares++;
                    $display("FAIL %s: got value=%0d done=%b busy=%b rcnt=%0d, want value=%0d done=%b busy=%b rcnt=%0d",
                             e.name, counter_value_o, done_o, busy_o, reload_cnt_o,
                             e.value, e.done, e.busy, e.rcnt);
                end
            end
        end
    end

    task automatic tick(input int v, input bit d, input bit b, input int r, input string name);
        exp_t e;
        e.value = 4'(v);
        e.done  = d;
        e.busy  = b;
        e.rcnt  = 4'(r);
        e.name  = name;
        q.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic cfg(input bit d, input bit m, input int init, input int inc, input int tgt);
        dir_i            = d;
        mode_i           = m;
        counter_init_i   = 4'(init);
        counter_inc_i    = 4'(inc);
        counter_target_i = 4'(tgt);
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; enable_i = 1'b1;
        cfg(0, 0, 0, 0, 0);
        @(negedge clk_i);
        tick(0, 0, 0, 0, "reset");
        reset_i = 1'b0;

        // Up one-shot 0..15 step 3.
        cfg(0, 0, 0, 3, 15); start_i = 1'b1;
        tick(0, 0, 1, 0, "up_start");
        start_i = 1'b0;
        for (int k = 1; k <= 4; k++) tick(3 * k, 0, 1, 0, "up_step");
        tick(15, 1, 0, 1, "up_done");
        tick(15, 1, 0, 1, "up_done_hold");

        // Overshoot clamp up, then down count.
        cfg(0, 0, 0, 4, 14); start_i = 1'b1;
        tick(0, 0, 1, 0, "clamp_start");
        start_i = 1'b0;
        tick(4, 0, 1, 0, "clamp_4");
        tick(8, 0, 1, 0, "clamp_8");
        tick(12, 0, 1, 0, "clamp_12");
        tick(14, 1, 0, 1, "clamp_14");
        cfg(1, 0, 15, 5, 2); start_i = 1'b1;
        tick(15, 0, 1, 0, "down_start");
        start_i = 1'b0;
        tick(10, 0, 1, 0, "down_10");
        tick(5, 0, 1, 0, "down_5");
        tick(2, 1, 0, 1, "down_2");

        // Auto-reload 2,4,6 with saturating reload count.
        cfg(0, 1, 2, 2, 6); start_i = 1'b1;
        tick(2, 0, 1, 0, "rl_start");
        start_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(4, 0, 1, (k - 1 > 15) ? 15 : k - 1, "rl_4");
            tick(6, 1, 1, (k > 15) ? 15 : k, "rl_6");
            tick(2, 0, 1, (k > 15) ? 15 : k, "rl_2");
        end

        // Auto-reload paused at target: no extra pulse, then reload to init.
        cfg(0, 1, 2, 2, 6); start_i = 1'b1;
        tick(2, 0, 1, 0, "rlp_start");
        start_i = 1'b0;
        tick(4, 0, 1, 0, "rlp_4");
        tick(6, 1, 1, 1, "rlp_6");
        enable_i = 1'b0;
        for (int k = 0; k < 3; k++) tick(6, 0, 1, 1, "rlp_pause");
        enable_i = 1'b1;
        tick(2, 0, 1, 1, "rlp_reload");
        tick(4, 0, 1, 1, "rlp_4b");
        tick(6, 1, 1, 2, "rlp_6b");

        // One-shot pause at 6, resume at 9, then abort at 9.
        cfg(0, 0, 0, 3, 15); start_i = 1'b1;
        tick(0, 0, 1, 0, "pause_start");
        start_i = 1'b0;
        tick(3, 0, 1, 0, "pause_3");
        tick(6, 0, 1, 0, "pause_6");
        enable_i = 1'b0;
        for (int k = 0; k < 3; k++) tick(6, 0, 1, 0, "pause_hold");
        enable_i = 1'b1;
        tick(9, 0, 1, 0, "pause_resume");
        abort_i = 1'b1;
        tick(9, 0, 0, 0, "abort");
        abort_i = 1'b0;
        tick(9, 0, 0, 0, "abort_idle_hold");

        // init past target, inc of zero, start+abort together.
        cfg(0, 0, 9, 1, 5); start_i = 1'b1;
        tick(5, 1, 0, 1, "past_target");
        start_i = 1'b0;
        tick(5, 1, 0, 1, "past_target_hold");
        cfg(0, 0, 0, 0, 3); start_i = 1'b1;
        tick(0, 0, 1, 0, "inc0_start");
        start_i = 1'b0;
        tick(1, 0, 1, 0, "inc0_1");
        tick(2, 0, 1, 0, "inc0_2");
        tick(3, 1, 0, 1, "inc0_3");
        cfg(0, 0, 0, 3, 15); start_i = 1'b1; abort_i = 1'b1;
        tick(3, 0, 0, 1, "start_abort");
        start_i = 1'b0; abort_i = 1'b0;
        tick(3, 0, 0, 1, "start_abort_idle");

        // Down auto-reload starting below target.
        cfg(1, 1, 2, 1, 5); start_i = 1'b1;
        tick(5, 1, 1, 1, "dn_rl_past");
        start_i = 1'b0;
        tick(2, 0, 1, 1, "dn_rl_reload");
        tick(5, 1, 1, 2, "dn_rl_term");

        // Reset mid-run, then a normal restart.
        cfg(0, 0, 0, 3, 15); start_i = 1'b1;
        tick(0, 0, 1, 0, "rst_start");
        start_i = 1'b0;
        for (int k = 1; k <= 4; k++) tick(3 * k, 0, 1, 0, "rst_step");
        reset_i = 1'b1;
        tick(0, 0, 0, 0, "reset_mid_run");
        reset_i = 1'b0;
        start_i = 1'b1;
        tick(0, 0, 1, 0, "post_reset_start");
        start_i = 1'b0;
        tick(3, 0, 1, 0, "post_reset_3");

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk_i);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_v2.md
Name: counter_v2

Overview:
Parametrised, run-time configurable step counter. It is the successor to the fixed +1 counter and the init/inc/target counter.
- Adds generic width, up/down direction, one-shot or auto-reload mode, overshoot clamping, start/abort control, pause via enable, and a reload event counter.
- Used as a general sequencing/timing primitive in datapath controllers.

Parameters:
- WIDTH, 4, bit width of counter value, init, increment and target.
- RELOAD_W, 4, bit width of the saturating reload event counter.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; latches configuration and (re)starts counting.
- abort_i  in  1  returns to IDLE; value is held.
- enable_i  in  1  step permission in RUN; low pauses the counter.
- dir_i  in  1  0 = count up, 1 = count down; sampled on start.
- mode_i  in  1  0 = one-shot, 1 = auto-reload; sampled on start.
- counter_init_i  in  WIDTH  start value; sampled on start.
- counter_inc_i  in  WIDTH  step size; sampled on start.
- counter_target_i  in  WIDTH  terminal value; sampled on start.
- counter_value_o  out  WIDTH  current count, registered.
- done_o  out  1  terminal indication, registered.
- busy_o  out  1  high while in RUN.
- reload_cnt_o  out  RELOAD_W  number of terminal events since start; saturates at all-ones.

Behaviour:
- One clock, clk_i. reset_i is synchronous and active-high. Priority: reset_i > abort_i > start_i > enable_i.
- Reset: state IDLE; counter_value_o=0, done_o=0, busy_o=0, reload_cnt_o=0; latched config registers cleared.
- States: IDLE, RUN, DONE. All outputs are registered.
- Config inputs are ignored except in a cycle with start_i=1.
- Start (in any state, no abort):
  - Latch dir, mode, init, inc and target. An inc of 0 is latched as 1.
  - counter_value_o <= init, reload_cnt_o <= 0, done_o <= 0, state <= RUN.
  - Exception: if init == target, or init is already past target (up: init>target; down: init<target), then counter_value_o <= target, done_o <= 1, reload_cnt_o <= 1, and state <= DONE (one-shot) or RUN (reload).
- Latency: start sampled at edge N gives value=init after edge N. The first step occurs at the first edge after N with enable_i=1.
- RUN, enable_i=0: all outputs hold; busy_o=1.
- RUN, enable_i=1, arithmetic:
  - Compare in WIDTH+1 bits with no wrap-around.
  - Up: if value+inc >= target, then value <= target (terminal event); else value <= value+inc.
  - Down: if value <= target+inc, then value <= target (terminal event); else value <= value-inc.
  - Overshoot is therefore clamped to exactly target.
- Terminal event:
  - done_o is 1 in the same cycle counter_value_o first shows target.
  - reload_cnt_o increments, saturating.
  - One-shot: state <= DONE, busy_o <= 0. done_o stays high (level) until start, abort or reset.
  - Auto-reload: state stays RUN and done_o is a one-cycle pulse. The next enabled step loads value <= init instead of stepping. Then counting resumes. If enable is low, value holds at target.
- DONE: value holds at target. Only start_i, abort_i or reset_i leave this state.
- Abort: state <= IDLE, done_o <= 0, busy_o <= 0. counter_value_o and reload_cnt_o hold.
- Start while RUN or DONE: an immediate restart with the new config. Any pending reload is discarded.
- Start and abort in the same cycle: abort wins.
- Reset mid-RUN: outputs return to reset values on that edge.

Test Plan:
- WIDTH=4, up, one-shot, init=0, inc=3, target=15, enable held high → value 0,3,6,9,12,15. done_o=1 with value 15, stays 1. busy_o drops. reload_cnt_o=1.
- Up, inc=4, target=14 → 0,4,8,12,14: clamped, no wrap to 0, done_o=1. Down, init=15, inc=5, target=2 → 15,10,5,2 then done_o=1.
- Auto-reload, init=2, inc=2, target=6 → 2,4,6(done pulse),2,4,6(pulse)… reload_cnt_o counts 1,2,3…; after 20 events it reads 15 (saturated).
- Toggle enable_i low for 3 cycles mid-count at value 6 (init 0, inc 3) → value holds 6 for 3 cycles, then resumes at 9. Same for auto-reload paused at target: value holds 6, no extra done pulse.
- Boundaries:
  - init=9 > target=5, up → value=5, done_o=1 one cycle after start.
  - inc=0 → behaves as inc=1.
  - abort at value 9 → IDLE, value 9 held, done_o=0.
  - start+abort together → IDLE.
- reset_i asserted mid-RUN (value 12) → next cycle value=0, done_o=0, busy_o=0, reload_cnt_o=0. A subsequent start works normally.
